// File: rtl/acc_src_select.sv
// Accumulator source selector: picks one of NUM_SRC flattened sources, waits
// (bounded by TIMEOUT) for non-always-valid sources, and loads the accumulator.
module acc_src_select #(
  parameter int                 DATA_W       = 8,
  parameter int                 NUM_SRC      = 7,
  parameter int                 SEL_W        = 3,
  parameter logic [NUM_SRC-1:0] ALWAYS_VALID = NUM_SRC'(7'b0000011),
  parameter int                 TIMEOUT      = 255,
  parameter int                 TMO_W        = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load,
  input  logic [SEL_W-1:0]          sel,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ack,
  output logic [DATA_W-1:0]         acc_out,
  output logic                      acc_loaded,
  output logic                      stall,
  output logic                      err_timeout,
  output logic                      err_badsel
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t             r_state;
  logic [TMO_W-1:0]   r_count;
  logic [SEL_W-1:0]   r_sel;
  logic [DATA_W-1:0]  r_acc;
  logic               r_loaded;
  logic               r_errTimeout;
  logic               r_errBadsel;

  state_t             w_nextState;
  logic [TMO_W-1:0]   w_nextCount;
  logic [SEL_W-1:0]   w_activeSel;
  logic               w_selOk;
  logic               w_srcReady;
  logic [DATA_W-1:0]  w_srcData;
  logic               w_tmoHit;
  logic               w_capture;
  logic               w_abort;
  logic               w_badsel;
  logic               w_enterWait;

  // In WAIT the latched select drives the mux; sel is only looked at in IDLE.
  always_comb begin
    w_activeSel = (r_state == S_IDLE) ? sel : r_sel;
    w_selOk     = ({1'b0, sel} < (SEL_W+1)'(NUM_SRC));
    w_srcReady  = 1'b0;
    w_srcData   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_activeSel == SEL_W'(i)) begin
        w_srcReady = ALWAYS_VALID[i] | src_valid[i];
        w_srcData  = src_data[i*DATA_W +: DATA_W];
      end
    end
    w_tmoHit = (r_count == TMO_W'(TIMEOUT - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_sel   <= '0;
    end else begin
      r_state <= w_nextState;
      r_count <= w_nextCount;
      if (w_enterWait) r_sel <= sel;
    end
  end

  // Events are suppressed while reset is high so a dropped load never acks.
  always_comb begin
    w_nextState = r_state;
    w_nextCount = r_count;
    w_capture   = 1'b0;
    w_abort     = 1'b0;
    w_badsel    = 1'b0;
    w_enterWait = 1'b0;
    if (!reset) begin
      case (r_state)
        S_IDLE: begin
          if (load) begin
            if (!w_selOk) begin
              w_badsel = 1'b1;
            end else if (w_srcReady) begin
              w_capture = 1'b1;
            end else begin
              w_enterWait = 1'b1;
              w_nextState = S_WAIT;
              w_nextCount = '0;
            end
          end
        end
        S_WAIT: begin
          if (w_srcReady) begin
            w_capture   = 1'b1;
            w_nextState = S_IDLE;
          end else if (w_tmoHit) begin
            w_abort     = 1'b1;
            w_nextState = S_IDLE;
            w_nextCount = '0;
          end else begin
            w_nextCount = r_count + TMO_W'(1);
          end
        end
        default: w_nextState = S_IDLE;
      endcase
    end
  end

  always_comb begin
    stall   = w_enterWait | ((r_state == S_WAIT) & ~reset & ~w_srcReady & ~w_tmoHit);
    src_ack = w_capture ? (NUM_SRC'(1) << w_activeSel) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc        <= '0;
      r_loaded     <= 1'b0;
      r_errTimeout <= 1'b0;
      r_errBadsel  <= 1'b0;
    end else begin
      if (w_capture) r_acc <= w_srcData;
      r_loaded     <= w_capture;
      r_errTimeout <= w_abort;
      r_errBadsel  <= w_badsel;
    end
  end

  assign acc_out     = r_acc;
  assign acc_loaded  = r_loaded;
  assign err_timeout = r_errTimeout;
  assign err_badsel  = r_errBadsel;

endmodule

// File: tb/tb_acc_src_select.sv
// Scoreboard bench for acc_src_select: driver models each request at the
// transaction level, monitor checks the registered pulses one cycle later.
module tb_acc_src_select;

  localparam int DW = 8;
  localparam int NS = 7;
  localparam int SW = 3;
  localparam int TO = 4;
  localparam logic [NS-1:0] AV = 7'b0000011;

  logic            clk = 1'b0;
  logic            reset;
  logic            load;
  logic [SW-1:0]   sel;
  logic [NS*DW-1:0] src_data;
  logic [NS-1:0]   src_valid;
  logic [NS-1:0]   src_ack;
  logic [DW-1:0]   acc_out;
  logic            acc_loaded;
  logic            stall;
  logic            err_timeout;
  logic            err_badsel;

  acc_src_select #(
    .DATA_W(DW), .NUM_SRC(NS), .SEL_W(SW), .ALWAYS_VALID(AV),
    .TIMEOUT(TO), .TMO_W(8)
  ) dut (
    .clk(clk), .reset(reset), .load(load), .sel(sel),
    .src_data(src_data), .src_valid(src_valid), .src_ack(src_ack),
    .acc_out(acc_out), .acc_loaded(acc_loaded), .stall(stall),
    .err_timeout(err_timeout), .err_badsel(err_badsel)
  );

  always #5 clk = ~clk;

  // flags = {acc_loaded, err_timeout, err_badsel}
  typedef struct {
    logic [2:0]    flags;
    logic [DW-1:0] acc;
  } exp_t;

  exp_t          sbQ[$];
  int            total = 0;
  int            bad = 0;
  bit            monOn = 1'b0;
  logic [DW-1:0] modelAcc = '0;
  int            pendSel = -1;
  int            waited = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NS*DW-1:0] mkData(input int idx, input logic [DW-1:0] val);
    logic [NS*DW-1:0] d;
    d = {$urandom(), $urandom()};
    d[idx*DW +: DW] = val;
    return d;
  endfunction

  // One clock cycle: drive inputs, predict the cycle's outcome, check
  // combinational outputs, and queue the registered response.
  task automatic applyStimulus(input logic rst, input logic ld, input logic [SW-1:0] s,
                               input logic [NS*DW-1:0] d, input logic [NS-1:0] v);
    logic [NS-1:0] expAck;
    logic          expStall;
    exp_t          e;
    bit            push;
    @(negedge clk);
    checkOutput("acc_out", acc_out, modelAcc);
    reset = rst; load = ld; sel = s; src_data = d; src_valid = v;
    #1;
    expAck = '0; expStall = 1'b0; push = 1'b0; e.flags = 3'b000; e.acc = modelAcc;
    if (rst) begin
      pendSel = -1; waited = 0; modelAcc = '0;
    end else if (pendSel < 0) begin
      if (ld) begin
        if (int'(s) >= NS) begin
          push = 1'b1; e.flags = 3'b001;
        end else if (AV[s] | v[s]) begin
          modelAcc = d[int'(s)*DW +: DW];
          expAck[s] = 1'b1;
          push = 1'b1; e.flags = 3'b100; e.acc = modelAcc;
        end else begin
          pendSel = int'(s); waited = 1; expStall = 1'b1;
        end
      end
    end else begin
      if (AV[pendSel] | v[pendSel]) begin
        modelAcc = d[pendSel*DW +: DW];
        expAck[pendSel] = 1'b1;
        push = 1'b1; e.flags = 3'b100; e.acc = modelAcc;
        pendSel = -1;
      end else if (waited == TO) begin
        push = 1'b1; e.flags = 3'b010;
        pendSel = -1; waited = 0;
      end else begin
        waited++; expStall = 1'b1;
      end
    end
    checkOutput("stall", 64'(stall), 64'(expStall));
    checkOutput("src_ack", 64'(src_ack), 64'(expAck));
    if (push) sbQ.push_back(e);
  endtask

  // Monitor: every cycle the registered pulses must match the queued event.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (monOn) begin
        if (sbQ.size() > 0) begin
          e = sbQ.pop_front();
          checkOutput("event_flags", 64'({acc_loaded, err_timeout, err_badsel}), 64'(e.flags));
          checkOutput("event_acc", 64'(acc_out), 64'(e.acc));
        end else begin
          checkOutput("idle_flags", 64'({acc_loaded, err_timeout, err_badsel}), 64'(3'b000));
        end
      end
    end
  end

  initial begin
    logic [NS-1:0] v;
    reset = 1'b1; load = 1'b0; sel = '0; src_data = '0; src_valid = '0;
    repeat (2) @(posedge clk);
    #1 monOn = 1'b1;

    // Immediate source load
    applyStimulus(0, 1, 3'd0, mkData(0, 8'hA5), 7'b0000000);
    applyStimulus(0, 0, 3'd0, '0, 7'b0000000);

    // Peripheral becomes valid after two wait cycles
    applyStimulus(0, 1, 3'd4, mkData(4, 8'h3C), 7'b0000000);
    applyStimulus(0, 0, 3'd0, mkData(4, 8'h3C), 7'b0000000);
    applyStimulus(0, 1, 3'd1, mkData(4, 8'h3C), 7'b0000000);
    applyStimulus(0, 0, 3'd0, mkData(4, 8'h3C), 7'b0010000);
    applyStimulus(0, 0, 3'd0, '0, 7'b0000000);

    // Timeout on a never-valid source with acc holding 8'h11
    applyStimulus(0, 1, 3'd1, mkData(1, 8'h11), 7'b0000000);
    applyStimulus(0, 1, 3'd5, mkData(5, 8'hEE), 7'b1011111);
    repeat (6) applyStimulus(0, 0, 3'd0, mkData(5, 8'hEE), 7'b0000000);

    // Bad select followed directly by a good load
    applyStimulus(0, 1, 3'd7, mkData(1, 8'h99), 7'b1111111);
    applyStimulus(0, 1, 3'd1, mkData(1, 8'h7E), 7'b0000000);
    applyStimulus(0, 0, 3'd0, '0, 7'b0000000);

    // Reset mid-wait while the source becomes valid
    applyStimulus(0, 1, 3'd4, mkData(4, 8'h55), 7'b0000000);
    applyStimulus(0, 0, 3'd0, mkData(4, 8'h55), 7'b0000000);
    applyStimulus(1, 0, 3'd0, mkData(4, 8'h55), 7'b0010000);
    applyStimulus(0, 0, 3'd0, mkData(4, 8'h55), 7'b0010000);

    // Back-to-back loads
    applyStimulus(0, 1, 3'd0, mkData(0, 8'h01), 7'b0000000);
    applyStimulus(0, 1, 3'd1, mkData(1, 8'h02), 7'b0000000);
    applyStimulus(0, 1, 3'd0, mkData(0, 8'h03), 7'b0000000);
    applyStimulus(0, 0, 3'd0, '0, 7'b0000000);

    // Randomised traffic with sparse valids and occasional resets
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < NS; b++) v[b] = ($urandom_range(9) < 3);
      applyStimulus(($urandom_range(99) == 0), $urandom_range(1), SW'($urandom_range(7)),
                    {$urandom(), $urandom()}, v);
    end

    repeat (TO + 2) applyStimulus(0, 0, 3'd0, '0, 7'b0000000);
    @(negedge clk);
    checkOutput("queue_drained", 64'(sbQ.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
